// File: rtl/accum_warp_retire_collector_if.sv
// rtl/accum_warp_retire_collector_if.sv - index-beat source and block-summary sink bundle for the retire collector
interface accum_warp_retire_collector_if #(
  parameter int N_CFG    = 4,
  parameter int MAX_WARP = 4
);
  localparam int NCFG_BW = $clog2(N_CFG + 1);
  localparam int WID_BW  = $clog2(MAX_WARP);
  localparam int CNT_BW  = WID_BW + 1;

  logic                           src_rdy;
  logic                           src_ack;
  logic [NCFG_BW-1:0]             i_id;
  logic [WID_BW-1:0]              i_warpid;
  logic                           i_retire;
  logic                           i_islast;
  logic                           dst_rdy;
  logic                           dst_ack;
  logic [CNT_BW-1:0]              o_nwarp;
  logic [N_CFG-1:0][CNT_BW-1:0]   o_retire_cnt;
  logic                           o_err;

  modport master (
    output src_rdy, i_id, i_warpid, i_retire, i_islast, dst_ack,
    input  src_ack, dst_rdy, o_nwarp, o_retire_cnt, o_err
  );

  modport slave (
    input  src_rdy, i_id, i_warpid, i_retire, i_islast, dst_ack,
    output src_ack, dst_rdy, o_nwarp, o_retire_cnt, o_err
  );
endinterface

// File: rtl/accum_warp_retire_collector.sv
// rtl/accum_warp_retire_collector.sv - per-block warp/retire collector; ACCUM_RETIRE_CHECK_EN adds protocol checks driving o_err
module accum_warp_retire_collector #(
  parameter int N_CFG    = 4,
  parameter int MAX_WARP = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  accum_warp_retire_collector_if.slave bus
);
  localparam int NCFG_BW = $clog2(N_CFG + 1);
  localparam int WID_BW  = $clog2(MAX_WARP);
  localparam int CNT_BW  = WID_BW + 1;

  typedef enum logic {COLLECT, REPORT} state_t;

  state_t                       state_q, state_d;
  logic                         src_ack, dst_rdy;
  logic                         accept, clear;
  logic [CNT_BW-1:0]            nwarp_q;
  logic [CNT_BW-1:0]            warp_p1;
  logic [N_CFG-1:0][CNT_BW-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    src_ack = 1'b0;
    dst_rdy = 1'b0;
    case (state_q)
      COLLECT: begin
        src_ack = bus.src_rdy;
        if (bus.src_rdy && bus.i_islast) state_d = REPORT;
      end
      REPORT: begin
        dst_rdy = 1'b1;
        if (bus.dst_ack) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign accept  = src_ack;
  assign clear   = dst_rdy && bus.dst_ack;
  assign warp_p1 = CNT_BW'(bus.i_warpid) + CNT_BW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      nwarp_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        nwarp_q <= '0;
        cnt_q   <= '0;
      end else if (accept) begin
        if (warp_p1 > nwarp_q) nwarp_q <= warp_p1;
        // Out-of-range ids never match an index, so they touch no counter.
        for (int i = 0; i < N_CFG; i++) begin
          if (bus.i_retire && bus.i_id == NCFG_BW'(i) && cnt_q[i] != CNT_BW'(MAX_WARP))
            cnt_q[i] <= cnt_q[i] + CNT_BW'(1);
        end
      end
    end
  end

`ifdef ACCUM_RETIRE_CHECK_EN
  logic                          err_q;
  logic                          have_prev_q;
  logic [WID_BW-1:0]             last_warp_q;
  logic [MAX_WARP-1:0][N_CFG-1:0] seen_q;
  logic                          id_ok, dup, sat, err_set;

  always_comb begin
    id_ok = bus.i_id < NCFG_BW'(N_CFG);
    dup   = 1'b0;
    sat   = 1'b0;
    for (int i = 0; i < N_CFG; i++) begin
      if (bus.i_id == NCFG_BW'(i)) begin
        dup = seen_q[bus.i_warpid][i];
        sat = cnt_q[i] == CNT_BW'(MAX_WARP);
      end
    end
    err_set = accept && ((have_prev_q && bus.i_warpid < last_warp_q) || !id_ok ||
                         (bus.i_retire && (dup || sat)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q       <= 1'b0;
      have_prev_q <= 1'b0;
      last_warp_q <= '0;
      seen_q      <= '0;
    end else if (clear) begin
      err_q       <= 1'b0;
      have_prev_q <= 1'b0;
      last_warp_q <= '0;
      seen_q      <= '0;
    end else if (accept) begin
      if (err_set) err_q <= 1'b1;
      have_prev_q <= 1'b1;
      last_warp_q <= bus.i_warpid;
      for (int i = 0; i < N_CFG; i++) begin
        if (bus.i_retire && bus.i_id == NCFG_BW'(i)) seen_q[bus.i_warpid][i] <= 1'b1;
      end
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.src_ack      = src_ack;
  assign bus.dst_rdy      = dst_rdy;
  assign bus.o_nwarp      = nwarp_q;
  assign bus.o_retire_cnt = cnt_q;
endmodule

// File: tb/tb_accum_warp_retire_collector.sv
// tb/tb_accum_warp_retire_collector.sv - directed vectors for the retire collector (N_CFG=4, MAX_WARP=4)
module tb_accum_warp_retire_collector;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

`ifdef ACCUM_RETIRE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  accum_warp_retire_collector_if #(.N_CFG(4), .MAX_WARP(4)) bus ();

  accum_warp_retire_collector #(.N_CFG(4), .MAX_WARP(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] id, input logic [1:0] warp, input logic ret, input logic last);
    @(negedge clk);
    bus.i_id     = id;
    bus.i_warpid = warp;
    bus.i_retire = ret;
    bus.i_islast = last;
    bus.src_rdy  = 1'b1;
    #1 chk("src_ack", 32'(bus.src_ack), 32'd1);
    @(posedge clk);
    #1 bus.src_rdy = 1'b0;
  endtask

  task automatic summary(input string tag, input logic [2:0] nw, input logic [11:0] cnt, input logic err);
    chk({tag, ".dst_rdy"}, 32'(bus.dst_rdy), 32'd1);
    chk({tag, ".nwarp"},   32'(bus.o_nwarp), 32'(nw));
    chk({tag, ".cnt"},     32'(bus.o_retire_cnt), 32'(cnt));
    chk({tag, ".err"},     32'(bus.o_err), 32'(err));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.dst_ack = 1'b1;
    @(posedge clk);
    #1 bus.dst_ack = 1'b0;
    chk({tag, ".clr_dst_rdy"}, 32'(bus.dst_rdy), 32'd0);
    chk({tag, ".clr_nwarp"},   32'(bus.o_nwarp), 32'd0);
    chk({tag, ".clr_cnt"},     32'(bus.o_retire_cnt), 32'd0);
    chk({tag, ".clr_err"},     32'(bus.o_err), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.src_rdy = 1'b0; bus.dst_ack = 1'b0;
    bus.i_id = '0; bus.i_warpid = '0; bus.i_retire = 1'b0; bus.i_islast = 1'b0;
    #12;
    chk("rst.dst_rdy", 32'(bus.dst_rdy), 32'd0);
    chk("rst.nwarp",   32'(bus.o_nwarp), 32'd0);
    chk("rst.cnt",     32'(bus.o_retire_cnt), 32'd0);
    chk("rst.err",     32'(bus.o_err), 32'd0);
    bus.src_rdy = 1'b1;
    #1 chk("rst.src_ack", 32'(bus.src_ack), 32'd1);
    bus.src_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single-beat block
    send(3'd0, 2'd0, 1'b1, 1'b1);
    summary("single", 3'd1, 12'h001, 1'b0);
    consume("single");

    // four warps, retire on id 2, then held in REPORT
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 3; i++)
        send(3'(i), 2'(w), 1'b1 && (i == 2), (w == 3) && (i == 2));
    summary("warps", 3'd4, 12'h100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.src_rdy = 1'b1;
      #1 chk("hold.src_ack", 32'(bus.src_ack), 32'd0);
      summary("hold", 3'd4, 12'h100, 1'b0);
    end
    bus.src_rdy = 1'b0;

    // dst_ack and src_rdy together in REPORT
    @(negedge clk);
    bus.dst_ack = 1'b1;
    bus.src_rdy = 1'b1;
    bus.i_id = 3'd1; bus.i_warpid = 2'd1; bus.i_retire = 1'b1; bus.i_islast = 1'b1;
    #1 chk("overlap.no_ack", 32'(bus.src_ack), 32'd0);
    @(posedge clk);
    #1 bus.dst_ack = 1'b0;
    chk("overlap.ack_next", 32'(bus.src_ack), 32'd1);
    chk("overlap.cnt0",     32'(bus.o_retire_cnt), 32'd0);
    @(posedge clk);
    #1 bus.src_rdy = 1'b0;
    summary("overlap", 3'd2, 12'h008, 1'b0);
    consume("overlap");

    // descending warp id
    send(3'd0, 2'd2, 1'b0, 1'b0);
    send(3'd0, 2'd1, 1'b0, 1'b1);
    summary("order", 3'd3, 12'h000, CHK);
    consume("order");

    // saturation of id 3
    for (int k = 0; k < 5; k++) send(3'd3, 2'd0, 1'b1, k == 4);
    summary("sat", 3'd1, 12'h800, CHK);
    consume("sat");

    // out-of-range id
    send(3'd5, 2'd0, 1'b1, 1'b1);
    summary("badid", 3'd1, 12'h000, CHK);
    consume("badid");

    // dst_ack while collecting is ignored
    send(3'd0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    bus.dst_ack = 1'b1;
    @(posedge clk);
    #1 bus.dst_ack = 1'b0;
    chk("stray_ack.nwarp", 32'(bus.o_nwarp), 32'd2);
    send(3'd1, 2'd1, 1'b1, 1'b1);
    summary("stray_ack", 3'd2, 12'h009, 1'b0);
    consume("stray_ack");

    // reset during REPORT
    send(3'd1, 2'd1, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rep.dst_rdy", 32'(bus.dst_rdy), 32'd0);
    chk("rst_rep.cnt",     32'(bus.o_retire_cnt), 32'd0);
    chk("rst_rep.nwarp",   32'(bus.o_nwarp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd2, 2'd0, 1'b1, 1'b1);
    summary("after_rst", 3'd1, 12'h040, 1'b0);
    consume("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/accum_warp_retire_collector.md
ACCUM_WARP_RETIRE_COLLECTOR -- requirements
Module: AccumWarpRetireCollector

Interface
REQ-001 SHALL have parameter N_CFG, default TauCfg::N_ICFG, the number of config ids per block.
REQ-002 SHALL have parameter MAX_WARP, default TauCfg::MAX_WARP, the number of warps per block.
REQ-003 SHALL derive NCFG_BW = $clog2(N_CFG+1), WID_BW = $clog2(MAX_WARP) and CNT_BW = WID_BW+1.
REQ-004 i_clk  input  1  clock; single clock domain.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 src_rdy  input  1  index beat valid.
REQ-007 src_ack  output  1  index beat accepted.
REQ-008 i_id  input  NCFG_BW  config id of the beat.
REQ-009 i_warpid  input  WID_BW  warp id of the beat.
REQ-010 i_retire  input  1  this beat retires config i_id for this warp.
REQ-011 i_islast  input  1  final beat of the block.
REQ-012 dst_rdy  output  1  block summary valid.
REQ-013 dst_ack  input  1  block summary consumed.
REQ-014 o_nwarp  output  CNT_BW  highest accepted warp id plus 1.
REQ-015 o_retire_cnt  output  CNT_BW x N_CFG  retire count per config id.
REQ-016 o_err  output  1  protocol violation seen in the block.

Function
REQ-017 SHALL implement two states: COLLECT and REPORT.
REQ-018 In COLLECT, SHALL drive src_ack = src_rdy combinationally and dst_rdy = 0.
REQ-019 In REPORT, SHALL drive src_ack = 0 and dst_rdy = 1; outputs SHALL hold stable until dst_ack.
REQ-020 Transfer SHALL occur only on a cycle with src_ack=1 (src side) or dst_ack=1 (dst side).
REQ-021 On an accepted beat with i_retire=1 and i_id<N_CFG, o_retire_cnt[i_id] SHALL increment by 1 on the next edge.
REQ-022 Counters SHALL saturate at MAX_WARP; a saturating increment SHALL set o_err when checking is compiled in.
REQ-023 On every accepted beat, o_nwarp SHALL become max(o_nwarp, i_warpid+1).
REQ-024 An accepted beat with i_islast=1 SHALL be counted like any other beat, and the state SHALL become REPORT on the same edge; dst_rdy SHALL rise one cycle after that acceptance.
REQ-025 On dst_ack in REPORT, the next edge SHALL clear o_nwarp, all o_retire_cnt entries and o_err to 0 and return the state to COLLECT; the next src beat can be acked that cycle.
REQ-026 dst_ack asserted while dst_rdy=0 SHALL be ignored.
REQ-027 i_id >= N_CFG with i_retire=1 SHALL NOT update any counter.

Reset
REQ-028 i_rst_n low SHALL immediately force the state to COLLECT and o_nwarp, all o_retire_cnt entries and o_err to 0; this makes src_ack follow src_rdy and dst_rdy 0.
REQ-029 Reset mid-block or mid-REPORT SHALL discard the partial summary with no dst transfer.

Configuration
REQ-030 Macro ACCUM_RETIRE_CHECK_EN controls protocol checking.
REQ-031 When ACCUM_RETIRE_CHECK_EN is defined, o_err SHALL be set (sticky until the dst_ack or reset) by any of the following:
- i_warpid lower than the previous accepted warp id in the block;
- i_id >= N_CFG;
- a second retire for the same id and warp;
- counter saturation.
REQ-032 When ACCUM_RETIRE_CHECK_EN is not defined, o_err SHALL be constant 0 and no check logic is instantiated.

Verification (N_CFG=4, MAX_WARP=4)
REQ-033 Reset, then src_rdy=1 with one beat (id 0, warp 0, retire 1, islast 1) -> src_ack same cycle; dst_rdy next cycle with o_nwarp=1, cnt={1,0,0,0}, o_err=0.
REQ-034 Warps 0..3, ids 0..2 each, retire on id 2, islast on the final beat -> o_nwarp=4, cnt={0,0,4,0}; dst held 3 cycles with dst_ack=0 -> outputs stable and src_ack=0 throughout.
REQ-035 dst_ack and src_rdy both high in REPORT -> no src_ack that cycle; the next beat is acked the following cycle; counters start from 0.
REQ-036 With ACCUM_RETIRE_CHECK_EN: warp 2 then warp 1 -> o_err=1 in the summary. Without the macro, the same stimulus -> o_err=0.
REQ-037 Retire id 3 four times, then a fifth with islast -> cnt[3]=4 (saturated); o_err=1 with the macro.
REQ-038 i_rst_n pulsed low during REPORT -> dst_rdy=0 immediately; all counts 0; the next beat is acked.
